// File: rtl/rlen_pkg.sv
// rlen_pkg: shared types and field helpers for the run-length decoder.
// Token layout is {last, count, symbol}, symbol in the LSBs.
package rlen_pkg;

  typedef logic [0:0] state_t;

  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  localparam int SYM_LSB = 0;

  function automatic int tok_width(int sw, int cw);
    return sw + cw + 1;
  endfunction

  function automatic int max_run(int cw, int bias);
    return (1 << cw) - 1 + bias;
  endfunction

  function automatic int cnt_lsb(int sw);
    return sw;
  endfunction

  function automatic int last_pos(int sw, int cw);
    return sw + cw;
  endfunction

endpackage

// File: rtl/rlen_dec_wrap.sv
// rlen_dec_wrap: power-pin shell around the run-length decoder.
// Supply pins exist only when USE_POWER_PINS is defined.
module rlen_dec_wrap
  import rlen_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 8,
  parameter int COUNT_WIDTH  = 4,
  parameter int LEN_BIAS     = 0
) (
`ifdef USE_POWER_PINS
  inout  wire  vccd1,
  inout  wire  vssd1,
`endif
  input  logic clk,
  input  logic reset,
  input  logic [tok_width(SYMBOL_WIDTH,COUNT_WIDTH)-1:0] rlen__input_r,
  input  logic rlen__input_r_vld,
  output logic rlen__input_r_rdy,
  output logic [SYMBOL_WIDTH:0] rlen__output_s,
  output logic rlen__output_s_vld,
  input  logic rlen__output_s_rdy,
  output logic rlen__err
);

  rlen_dec #(
    .SYMBOL_WIDTH(SYMBOL_WIDTH),
    .COUNT_WIDTH (COUNT_WIDTH),
    .LEN_BIAS    (LEN_BIAS)
  ) u_core (
    .clk               (clk),
    .reset             (reset),
    .rlen__input_r     (rlen__input_r),
    .rlen__input_r_vld (rlen__input_r_vld),
    .rlen__input_r_rdy (rlen__input_r_rdy),
    .rlen__output_s    (rlen__output_s),
    .rlen__output_s_vld(rlen__output_s_vld),
    .rlen__output_s_rdy(rlen__output_s_rdy),
    .rlen__err         (rlen__err)
  );

endmodule

// File: rtl/rlen_dec.sv
// rlen_dec: run-length decoder core.
// Expands {last, count, symbol} tokens into repeated symbol beats.
module rlen_dec
  import rlen_pkg::*;
#(
  parameter int SYMBOL_WIDTH = 8,
  parameter int COUNT_WIDTH  = 4,
  parameter int LEN_BIAS     = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic [tok_width(SYMBOL_WIDTH,COUNT_WIDTH)-1:0] rlen__input_r,
  input  logic rlen__input_r_vld,
  output logic rlen__input_r_rdy,
  output logic [SYMBOL_WIDTH:0] rlen__output_s,
  output logic rlen__output_s_vld,
  input  logic rlen__output_s_rdy,
  output logic rlen__err
);

  localparam int LAST_BIT = last_pos(SYMBOL_WIDTH, COUNT_WIDTH);
  localparam int CNT_LSB  = cnt_lsb(SYMBOL_WIDTH);
  localparam int RW       = COUNT_WIDTH + 1;
  localparam logic [RW-1:0] BIAS = RW'(LEN_BIAS);
  localparam logic [RW-1:0] ONE  = RW'(1);

  state_t                  state;
  logic [SYMBOL_WIDTH-1:0] sym;
  logic                    last_q;
  logic [RW-1:0]           rem;
  logic                    err;

  logic                    tok_last;
  logic [COUNT_WIDTH-1:0]  tok_cnt;
  logic [SYMBOL_WIDTH-1:0] tok_sym;
  logic [RW-1:0]           tok_len;
  logic                    final_beat;
  logic                    in_rdy;
  logic                    acc;
  logic                    fire;

  assign tok_last = rlen__input_r[LAST_BIT];
  assign tok_cnt  = rlen__input_r[LAST_BIT-1:CNT_LSB];
  assign tok_sym  = rlen__input_r[CNT_LSB-1:SYM_LSB];
  assign tok_len  = {1'b0, tok_cnt} + BIAS;

  // Ready never looks at input valid; final beat chains to the next token.
  assign final_beat = (state == RUN) && (rem == ONE);
  assign in_rdy = reset
               && ((state == IDLE)
                || (final_beat && rlen__output_s_rdy));
  assign acc  = rlen__input_r_vld && in_rdy;
  assign fire = (state == RUN) && rlen__output_s_rdy;

  // Token load, beat countdown and sticky zero-length-last error.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sym    <= '0;
      last_q <= 1'b0;
      rem    <= '0;
      err    <= 1'b0;
    end else begin
      if (acc && (tok_len != '0)) begin
        state  <= RUN;
        sym    <= tok_sym;
        last_q <= tok_last;
        rem    <= tok_len;
      end else if (acc) begin
        state <= IDLE;
        rem   <= '0;
      end else if (fire) begin
        rem <= rem - ONE;
        if (rem == ONE) state <= IDLE;
      end
      if (acc && (tok_len == '0) && tok_last) err <= 1'b1;
    end
  end

  assign rlen__input_r_rdy  = in_rdy;
  assign rlen__output_s_vld = (state == RUN);
  assign rlen__output_s     = {last_q && (rem == ONE), sym};
  assign rlen__err          = err;

endmodule

// File: tb/tb_rlen_dec.sv
// tb_rlen_dec: directed and random checks of rlen_dec instances
// against a queue-based expansion model of the token stream.
module tb_rlen_dec;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int sw   [3] = '{8, 8, 1};
  int cw   [3] = '{4, 4, 2};
  int bias [3] = '{0, 1, 0};

  logic [12:0] tin [3];
  logic        tv  [3];
  logic        orr [3];
  logic        tr  [3];
  logic        ov  [3];
  logic        er  [3];
  logic [8:0]  os  [3];

  logic [8:0] os0, os1;
  logic [1:0] os2;
  logic r0, r1, r2, v0, v1, v2, e0, e1, e2;

  rlen_dec u0 (
    .clk(clk), .reset(rst_n),
    .rlen__input_r(tin[0]), .rlen__input_r_vld(tv[0]),
    .rlen__input_r_rdy(r0), .rlen__output_s(os0),
    .rlen__output_s_vld(v0), .rlen__output_s_rdy(orr[0]),
    .rlen__err(e0)
  );

  rlen_dec #(.SYMBOL_WIDTH(8), .COUNT_WIDTH(4), .LEN_BIAS(1)) u1 (
    .clk(clk), .reset(rst_n),
    .rlen__input_r(tin[1]), .rlen__input_r_vld(tv[1]),
    .rlen__input_r_rdy(r1), .rlen__output_s(os1),
    .rlen__output_s_vld(v1), .rlen__output_s_rdy(orr[1]),
    .rlen__err(e1)
  );

  rlen_dec_wrap #(.SYMBOL_WIDTH(1), .COUNT_WIDTH(2), .LEN_BIAS(0)) u2 (
    .clk(clk), .reset(rst_n),
    .rlen__input_r(tin[2][3:0]), .rlen__input_r_vld(tv[2]),
    .rlen__input_r_rdy(r2), .rlen__output_s(os2),
    .rlen__output_s_vld(v2), .rlen__output_s_rdy(orr[2]),
    .rlen__err(e2)
  );

  always_comb begin
    tr[0] = r0; tr[1] = r1; tr[2] = r2;
    ov[0] = v0; ov[1] = v1; ov[2] = v2;
    er[0] = e0; er[1] = e1; er[2] = e2;
    os[0] = os0; os[1] = os1; os[2] = {7'b0, os2};
  end

  logic [8:0] expq [3][$];
  logic       experr [3];
  int         xfers [3];

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h want=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [12:0] mk(int k, int la, int cn, int sy);
    return 13'((la << (sw[k] + cw[k])) | (cn << sw[k]) | sy);
  endfunction

  // Reference: a token of length L becomes L beats, last on the final one.
  function automatic void expand(int k, logic [12:0] t);
    int s   = sw[k];
    int c   = cw[k];
    int v   = int'(t);
    int sy  = v & ((1 << s) - 1);
    int cn  = (v >> s) & ((1 << c) - 1);
    int la  = (v >> (s + c)) & 1;
    int len = cn + bias[k];
    if (len == 0 && la == 1) experr[k] = 1'b1;
    for (int i = 0; i < len; i++)
      expq[k].push_back(9'((((i == len - 1) && la == 1) ? (1 << s) : 0) | sy));
  endfunction

  always @(negedge clk) begin
    for (int k = 0; k < 3; k++) begin
      if (!rst_n) begin
        check($sformatf("rst_vld%0d", k), ov[k], 0);
        check($sformatf("rst_rdy%0d", k), tr[k], 0);
        check($sformatf("rst_out%0d", k), os[k], 0);
        check($sformatf("rst_err%0d", k), er[k], 0);
      end else begin
        check($sformatf("vld%0d", k), ov[k], expq[k].size() != 0);
        check($sformatf("rdy%0d", k), tr[k],
              expq[k].size() == 0 || (expq[k].size() == 1 && orr[k]));
        check($sformatf("err%0d", k), er[k], experr[k]);
        if (expq[k].size() != 0) begin
          check($sformatf("data%0d", k), os[k], expq[k][0]);
          if (orr[k]) begin
            void'(expq[k].pop_front());
            xfers[k]++;
          end
        end
        if (tv[k] && tr[k]) expand(k, tin[k]);
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 3; k++) begin
      expq[k].delete();
      experr[k] = 1'b0;
    end
  endtask

  task automatic put(int k, logic [12:0] t);
    int n = 0;
    tin[k] = t;
    tv[k]  = 1'b1;
    forever begin
      @(negedge clk);
      if (tr[k] && rst_n) break;
      n++;
      if (n > 200) begin
        check($sformatf("put_rdy%0d", k), tr[k], 1);
        break;
      end
    end
    @(posedge clk); #1;
    tv[k] = 1'b0;
  endtask

  task automatic drain(int k);
    orr[k] = 1'b1;
    for (int n = 0; n < 100 && expq[k].size() != 0; n++)
      @(negedge clk);
    @(posedge clk); #1;
    check($sformatf("drain%0d", k), expq[k].size(), 0);
  endtask

  task automatic rand_run(int k, int n);
    bit done = 1'b0;
    fork
      begin
        for (int i = 0; i < n; i++)
          put(k, mk(k, $urandom_range(0, 1),
                    $urandom_range(0, (1 << cw[k]) - 1),
                    $urandom_range(0, (1 << sw[k]) - 1)));
        done = 1'b1;
      end
      begin
        while (!done) begin
          orr[k] = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
    join
    drain(k);
  endtask

  int pat [7] = '{1, 0, 0, 1, 1, 0, 1};
  int b;

  initial begin
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tin[k] = '0; tv[k] = 1'b0; orr[k] = 1'b0;
      experr[k] = 1'b0; xfers[k] = 0;
    end
    #2 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("rel0_rdy", tr[0], 1);

    orr[0] = 1'b1;
    b = xfers[0];
    put(0, mk(0, 0, 3, 'hA5));
    put(0, mk(0, 1, 2, 'h3C));
    drain(0);
    check("b2b_beats", xfers[0] - b, 5);

    orr[0] = 1'b1;
    b = xfers[0];
    put(0, mk(0, 1, 4, 'h7E));
    for (int i = 0; i < 7; i++) begin
      orr[0] = 1'(pat[i]);
      @(posedge clk); #1;
    end
    orr[0] = 1'b0;
    check("bp_beats", xfers[0] - b, 4);
    check("bp_empty", expq[0].size(), 0);

    orr[0] = 1'b1;
    put(0, mk(0, 0, 0, 'h11));
    @(posedge clk); #1;
    check("zc_err0", er[0], 0);
    check("zc_vld", ov[0], 0);
    put(0, mk(0, 1, 0, 'h22));
    #1 check("zc_err1", er[0], 1);
    put(0, mk(0, 0, 2, 'h55));
    drain(0);
    check("zc_sticky", er[0], 1);

    b = xfers[0];
    put(0, mk(0, 1, 15, 'h5A));
    drain(0);
    check("max_beats", xfers[0] - b, 15);

    orr[1] = 1'b1;
    b = xfers[1];
    put(1, mk(1, 0, 15, 'h01));
    drain(1);
    check("bias_max", xfers[1] - b, 16);
    b = xfers[1];
    put(1, mk(1, 1, 0, 'h02));
    drain(1);
    check("bias_one", xfers[1] - b, 1);
    check("bias_err", er[1], 0);

    orr[0] = 1'b1;
    b = xfers[0];
    put(0, mk(0, 0, 5, 'h33));
    for (int n = 0; n < 50 && xfers[0] - b < 2; n++)
      @(negedge clk);
    check("mid_beats", xfers[0] - b, 2);
    @(posedge clk); #3;
    rst_n = 1'b0;
    clear_model();
    #1 check("mid_vld", ov[0], 0);
    check("mid_rdy", tr[0], 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    #1 check("mid_rel_rdy", tr[0], 1);
    check("mid_rel_vld", ov[0], 0);
    b = xfers[0];
    put(0, mk(0, 1, 1, 'h44));
    drain(0);
    check("mid_next", xfers[0] - b, 1);

    rand_run(0, 30);
    rand_run(2, 80);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/rlen_dec.md
# rlen_dec

Parametrised run-length decoder, successor to the fixed-width 1-bit RLE decoder. Accepts `{last, count, symbol}` tokens on a valid/ready input channel. Emits each symbol `count` times (or `count+1` times, depending on mode) on a valid/ready output channel, and carries the frame `last` flag to the final repetition. It sits between the tapeout's compressed-pattern source and the sample/bit consumers, and is instantiated through a power-pin wrapper like the other channel blocks.

## Interface
- `SYMBOL_WIDTH`, default 8: symbol width in bits, ≥1.
- `COUNT_WIDTH`, default 4: run-count field width in bits, ≥1.
- `LEN_BIAS`, default 0: 0 means run length = count and zero-count tokens are legal; 1 means run length = count+1.
- `clk`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `rlen__input_r`  in  SYMBOL_WIDTH+COUNT_WIDTH+1  token; MSB = last, then count, LSBs = symbol.
- `rlen__input_r_vld`  in  1  token valid.
- `rlen__input_r_rdy`  out  1  token ready.
- `rlen__output_s`  out  SYMBOL_WIDTH+1  MSB = last, LSBs = symbol.
- `rlen__output_s_vld`  out  1  output valid.
- `rlen__output_s_rdy`  in  1  output ready.
- `rlen__err`  out  1  sticky protocol error (zero-length token carrying last).

## Operation
- A transfer occurs on any edge where vld and rdy are both high; this applies to both channels.
- The state is IDLE or RUN. The registers are `sym`, `last_q`, and `rem` (beats remaining, COUNT_WIDTH+1 bits).
- IDLE:
  - `input_r_rdy` = 1 and `output_s_vld` = 0.
  - On accepting a token with run length L:
    - L ≥ 1: load `sym` and `last_q`, set `rem` = L, go to RUN.
    - L = 0 (only possible when LEN_BIAS=0): drop the token and stay IDLE.
    - L = 0 with last = 1: also set `err`.
- RUN:
  - `output_s_vld` = 1 and `output_s` = `{last_q && rem==1, sym}`.
  - Each output transfer decrements `rem`.
- Final beat (`rem`==1):
  - `input_r_rdy` = `output_s_rdy`. This is a combinational path, and it gives back-to-back tokens with no bubble.
  - If a token is accepted on the final beat, it loads as it would from IDLE: L ≥ 1 stays in RUN, L = 0 goes to IDLE.
  - If no token is accepted, go to IDLE after the final transfer.
- Non-final RUN beats: `input_r_rdy` = 0.
- The maximum run is 2^COUNT_WIDTH − 1 + LEN_BIAS. `rem` is one bit wider than the count field, so it never wraps.
- `err` is sticky and is cleared only by reset. The error does not stall the data path.

## Timing
- Reset asserted (asynchronous):
  - `output_s_vld` = 0, `output_s` = 0, `err` = 0.
  - `input_r_rdy` = 0 while reset is held.
  - State = IDLE, `rem` = 0.
- After reset release, `input_r_rdy` = 1 in the first cycle.
- Latency: a token accepted at edge N gives its first output valid after edge N (the following cycle). All output data is registered.
- Throughput: one output beat per cycle when `output_s_rdy` = 1. A stream of L≥1 tokens produces a continuous output with no idle cycles.
- Under backpressure:
  - `output_s` and `output_s_vld` stay stable until the transfer completes.
  - Valid is never withdrawn once asserted.
- `input_r_rdy` must not depend on `input_r_vld`.
- If reset asserts mid-run, the remaining beats are discarded. No output is produced after release until a new token arrives.

## Structure
- Package `rlen_pkg` holds:
  - the state enum (IDLE, RUN);
  - the helper functions `tok_width(SW,CW)` and `max_run(CW,BIAS)`;
  - the field-slice localparams for last, count and symbol positions.
- The core module `rlen_dec` needs no sub-module.
- The power-pin wrapper `rlen_dec_wrap` exposes the same ports under `USE_POWER_PINS`.

## Test plan
Default parameters (SYMBOL_WIDTH=8, COUNT_WIDTH=4, LEN_BIAS=0) unless stated.
- **Back-to-back tokens:**
  - Stimulus: tokens {0,3,0xA5} then {1,2,0x3C}, `output_rdy` held at 1.
  - Required: five consecutive beats 0x0A5, 0x0A5, 0x0A5, 0x03C, 0x13C.
  - Required: `input_rdy` is high during the third 0xA5 beat, with no bubble before 0x3C.
- **Backpressure:**
  - Stimulus: token {1,4,0x7E}, `output_rdy` = 1,0,0,1,1,0,1.
  - Required: data and valid are held stable during every stalled cycle.
  - Required: exactly four transfers; the last carries bit8=1. `input_rdy` stays low until the fourth beat is offered.
- **Zero-count tokens:**
  - Stimulus: {0,0,0x11} in IDLE.
  - Required: consumed in one cycle, no output, `err` stays 0.
  - Stimulus: then {1,0,0x22}.
  - Required: `err` rises and stays 1 through subsequent valid traffic.
- **Maximum run and bias:**
  - Stimulus: {1,15,0x5A}.
  - Required: exactly 15 beats, last on the 15th.
  - Stimulus: with LEN_BIAS=1, {0,15,0x01}.
  - Required: 16 beats.
  - Stimulus: with LEN_BIAS=1, {1,0,0x02}.
  - Required: exactly one beat 0x102, and `err` never set.
- **Reset mid-run:**
  - Stimulus: token {0,5,0x33}; assert reset asynchronously after 2 beats.
  - Required: `output_vld` drops immediately and `input_rdy` is low while reset is held.
  - Required: after release, `input_rdy` = 1 with no residual beats. The next token {1,1,0x44} yields the single beat 0x144.
- **Width sweep:**
  - Stimulus: SYMBOL_WIDTH=1, COUNT_WIDTH=2, random token stream with random `output_rdy`.
  - Required: a scoreboard expansion of the tokens matches the output exactly, including last placement.
